// File: rtl/alu_sel_pkg.sv
// Shared selector definitions for the datapath operand muxes (ALU-A, ALU-B, PC source).
// Maps a selector code to a source kind and a data-source index.
package alu_sel_pkg;

    localparam int unsigned SEL_DATA0      = 0;
    localparam int unsigned SEL_CONST      = 1;
    localparam int unsigned CONST_VAL_DFLT = 4;

    typedef enum logic [1:0] {
        SRC_DATA    = 2'd0,
        SRC_CONST   = 2'd1,
        SRC_ILLEGAL = 2'd2
    } src_kind_t;

    typedef struct packed {
        src_kind_t   kind;
        logic [31:0] idx;
    } src_map_t;

    // Code 0 -> data 0, code 1 -> constant, codes 2..n_data -> data code-1.
    function automatic src_map_t sel_decode(input int unsigned code, input int unsigned n_data);
        src_map_t m;
        m.kind = SRC_ILLEGAL;
        m.idx  = '0;
        if (code == SEL_DATA0) begin
            m.kind = SRC_DATA;
        end else if (code == SEL_CONST) begin
            m.kind = SRC_CONST;
        end else if (code <= n_data) begin
            m.kind = SRC_DATA;
            m.idx  = code - 1;
        end
        return m;
    endfunction

endpackage

// File: rtl/alu_b_operand_reg_if.sv
// Source-side and ALU-side handshake bundle for the registered ALU B-operand stage.
interface alu_b_operand_reg_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N_DATA = 3,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned CNT_W  = 8
);
    logic [SEL_W-1:0]        sel;
    logic [N_DATA*WIDTH-1:0] data_in;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        data_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err_sel;
    logic [CNT_W-1:0]        err_cnt;
    logic                    err_clr;

    modport master (
        output sel, data_in, in_valid, out_ready, err_clr,
        input  in_ready, data_out, out_valid, err_sel, err_cnt
    );

    modport slave (
        input  sel, data_in, in_valid, out_ready, err_clr,
        output in_ready, data_out, out_valid, err_sel, err_cnt
    );
endinterface

// File: rtl/alu_b_sel_decode.sv
// Combinational B-operand source select: picks a data source or the constant,
// and flags selector codes that map to no source.
module alu_b_sel_decode
    import alu_sel_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned N_DATA    = 3,
    parameter int unsigned CONST_VAL = CONST_VAL_DFLT,
    parameter int unsigned SEL_W     = 2
) (
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [N_DATA*WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0]        o_value,
    output logic                    o_illegal
);

    src_map_t w_map;

    always_comb begin
        w_map     = sel_decode(32'(i_sel), N_DATA);
        o_value   = '0;
        o_illegal = 1'b0;
        case (w_map.kind)
            SRC_CONST: o_value = WIDTH'(CONST_VAL);
            SRC_DATA: begin
                for (int unsigned j = 0; j < N_DATA; j++) begin
                    if (j == w_map.idx) begin
                        o_value = i_data_in[j*WIDTH +: WIDTH];
                    end
                end
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_b_operand_reg.sv
// Registered ALU B-operand selector: one-entry valid/ready output stage with
// illegal-selector drop, sticky error flag and saturating error counter.
module alu_b_operand_reg
    import alu_sel_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned N_DATA    = 3,
    parameter int unsigned CONST_VAL = CONST_VAL_DFLT,
    parameter int unsigned SEL_W     = ($clog2(N_DATA + 1) > 0) ? $clog2(N_DATA + 1) : 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_b_operand_reg_if.slave   bus
);

    logic [WIDTH-1:0] w_value;
    logic             w_illegal;
    logic             w_in_ready;
    logic             w_accept;

    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_err_sel;
    logic [CNT_W-1:0] r_err_cnt;

    alu_b_sel_decode #(
        .WIDTH    (WIDTH),
        .N_DATA   (N_DATA),
        .CONST_VAL(CONST_VAL),
        .SEL_W    (SEL_W)
    ) u_decode (
        .i_sel    (bus.sel),
        .i_data_in(bus.data_in),
        .o_value  (w_value),
        .o_illegal(w_illegal)
    );

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_illegal) begin
            r_data_out  <= w_value;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            // Covers both a plain consume and an illegal accept: the word leaves, data_out stays stale.
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_sel <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_accept && w_illegal) begin
            r_err_sel <= 1'b1;
            if (bus.err_clr) begin
                r_err_cnt <= CNT_W'(1);
            end else if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end else if (bus.err_clr) begin
            r_err_sel <= 1'b0;
            r_err_cnt <= '0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.data_out  = r_data_out;
    assign bus.out_valid = r_out_valid;
    assign bus.err_sel   = r_err_sel;
    assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_alu_b_operand_reg.sv
// Directed bench for alu_b_operand_reg: default build (N_DATA=3) and a
// reduced build (N_DATA=2, CNT_W=2) that has an illegal selector code.
module tb_alu_b_operand_reg;

    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    alu_b_operand_reg_if #(.WIDTH(WIDTH), .N_DATA(3), .SEL_W(2), .CNT_W(8)) ia ();
    alu_b_operand_reg_if #(.WIDTH(WIDTH), .N_DATA(2), .SEL_W(2), .CNT_W(2)) ib ();

    alu_b_operand_reg #(
        .WIDTH(WIDTH), .N_DATA(3), .CONST_VAL(4), .SEL_W(2), .CNT_W(8)
    ) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (ia.slave)
    );

    alu_b_operand_reg #(
        .WIDTH(WIDTH), .N_DATA(2), .CONST_VAL(4), .SEL_W(2), .CNT_W(2)
    ) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b0;
        ia.sel = '0; ia.data_in = '0; ia.in_valid = 1'b0; ia.out_ready = 1'b0; ia.err_clr = 1'b0;
        ib.sel = '0; ib.data_in = '0; ib.in_valid = 1'b0; ib.out_ready = 1'b0; ib.err_clr = 1'b0;

        #12;
        chk("rst_data",    64'(ia.data_out),  64'h0);
        chk("rst_valid",   64'(ia.out_valid), 64'h0);
        chk("rst_errsel",  64'(ia.err_sel),   64'h0);
        chk("rst_errcnt",  64'(ia.err_cnt),   64'h0);
        chk("rst_inready", 64'(ia.in_ready),  64'h1);
        reset = 1'b1;
        step();

        // sel=0 passes data 0, then drains on an idle cycle
        ia.sel = 2'd0; ia.data_in = {32'h0, 32'h0, 32'h0000_00AA};
        ia.in_valid = 1'b1; ia.out_ready = 1'b1;
        step();
        chk("sel0_data",  64'(ia.data_out),  64'hAA);
        chk("sel0_valid", 64'(ia.out_valid), 64'h1);
        ia.in_valid = 1'b0;
        step();
        chk("idle_valid", 64'(ia.out_valid), 64'h0);
        chk("idle_data",  64'(ia.data_out),  64'hAA);

        // constant, then back-to-back data 2 and data 1
        ia.sel = 2'd1; ia.data_in = {96{1'b1}}; ia.in_valid = 1'b1;
        step();
        chk("const_data",  64'(ia.data_out),  64'h4);
        chk("const_valid", 64'(ia.out_valid), 64'h1);
        ia.sel = 2'd3; ia.data_in = {32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        step();
        chk("sel3_data",  64'(ia.data_out),  64'h1234_5678);
        chk("sel3_valid", 64'(ia.out_valid), 64'h1);
        ia.sel = 2'd2; ia.data_in = {32'h0, 32'h0000_0055, 32'h0};
        step();
        chk("sel2_data",  64'(ia.data_out),  64'h55);
        chk("sel2_valid", 64'(ia.out_valid), 64'h1);
        ia.in_valid = 1'b0;
        step();

        // stall for 3 cycles with a queued input, then release
        ia.out_ready = 1'b0; ia.sel = 2'd0; ia.data_in = {32'h0, 32'h0, 32'h11}; ia.in_valid = 1'b1;
        step();
        chk("stall_first_data", 64'(ia.data_out), 64'h11);
        ia.sel = 2'd2; ia.data_in = {32'h0, 32'h22, 32'h0};
        #1;
        chk("stall_inready", 64'(ia.in_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data",    64'(ia.data_out),  64'h11);
            chk("stall_valid",   64'(ia.out_valid), 64'h1);
            chk("stall_inready", 64'(ia.in_ready),  64'h0);
        end
        ia.out_ready = 1'b1;
        #1;
        chk("release_inready", 64'(ia.in_ready), 64'h1);
        step();
        chk("release_data",  64'(ia.data_out),  64'h22);
        chk("release_valid", 64'(ia.out_valid), 64'h1);
        ia.in_valid = 1'b0;
        step();
        chk("release_drain", 64'(ia.out_valid), 64'h0);
        chk("a_no_err",      64'(ia.err_sel),   64'h0);

        // reduced build: sel=3 is illegal
        ib.sel = 2'd2; ib.data_in = {32'h77, 32'h0}; ib.in_valid = 1'b1; ib.out_ready = 1'b1;
        step();
        chk("b_legal_data",  64'(ib.data_out),  64'h77);
        chk("b_legal_valid", 64'(ib.out_valid), 64'h1);
        ib.sel = 2'd3;
        step();
        chk("b_ill_valid",  64'(ib.out_valid), 64'h0);
        chk("b_ill_data",   64'(ib.data_out),  64'h77);
        chk("b_ill_errsel", 64'(ib.err_sel),   64'h1);
        chk("b_ill_errcnt", 64'(ib.err_cnt),   64'h1);
        for (int i = 0; i < 4; i++) step();
        chk("b_sat_errcnt", 64'(ib.err_cnt), 64'h3);
        ib.in_valid = 1'b0; ib.err_clr = 1'b1;
        step();
        chk("b_clr_errcnt", 64'(ib.err_cnt), 64'h0);
        chk("b_clr_errsel", 64'(ib.err_sel), 64'h0);
        ib.err_clr = 1'b0; ib.in_valid = 1'b1;
        step();
        step();
        chk("b_two_errcnt", 64'(ib.err_cnt), 64'h2);
        ib.err_clr = 1'b1;
        step();
        chk("b_clrset_errcnt", 64'(ib.err_cnt), 64'h1);
        chk("b_clrset_errsel", 64'(ib.err_sel), 64'h1);
        ib.err_clr = 1'b0; ib.in_valid = 1'b0;

        // async reset while stalled with a valid word
        ia.out_ready = 1'b0; ia.sel = 2'd0; ia.data_in = {32'h0, 32'h0, 32'h99}; ia.in_valid = 1'b1;
        step();
        chk("prerst_valid", 64'(ia.out_valid), 64'h1);
        ia.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_data",    64'(ia.data_out),  64'h0);
        chk("async_valid",   64'(ia.out_valid), 64'h0);
        chk("async_b_errsel", 64'(ib.err_sel),  64'h0);
        chk("async_b_errcnt", 64'(ib.err_cnt),  64'h0);
        #1;
        reset = 1'b1;
        step();
        chk("postrst_valid",   64'(ia.out_valid), 64'h0);
        chk("postrst_inready", 64'(ia.in_ready),  64'h1);
        step();
        chk("postrst_valid2",  64'(ia.out_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
